// File: rtl/normalizador_float.sv
// Normalises and rounds the 54-bit significand product of a float multiplier
// into an IEEE-754 single-precision result (round to nearest even, flush to zero).
module normalizador_float (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [53:0] produto,
    input  logic [9:0]  expoente,
    input  logic        sinal,
    output logic [31:0] resultado,
    output logic        done,
    output logic        busy,
    output logic        overflow,
    output logic        underflow
);

    // state | meaning
    // IDLE  | waiting for start; outputs hold, done low
    // NORM  | shift significand left until bit 53 is set
    // ROUND | round to nearest even, pack result, pulse done
    typedef enum logic [1:0] {IDLE, NORM, ROUND} state_t;

    state_t             state;
    logic [53:0]        sig;
    logic signed [10:0] exp_w;
    logic               sgn;
    logic               zero_flag;

    logic [22:0]        frac;
    logic               guard;
    logic               sticky;
    logic               round_up;
    logic [23:0]        frac_sum;
    logic signed [10:0] exp_rnd;

    always_comb begin
        frac     = sig[52:30];
        guard    = sig[29];
        sticky   = |sig[28:0];
        round_up = guard & (sticky | frac[0]);
        frac_sum = {1'b0, frac} + {23'b0, round_up};
        // a carry out of the fraction leaves it zero and bumps the exponent
        exp_rnd  = frac_sum[23] ? exp_w + 11'sd1 : exp_w;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            sig       <= '0;
            exp_w     <= '0;
            sgn       <= 1'b0;
            zero_flag <= 1'b0;
            resultado <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sig       <= produto;
                        exp_w     <= $signed({expoente[9], expoente}) + 11'sd1;
                        sgn       <= sinal;
                        zero_flag <= (produto == 54'd0);
                        busy      <= 1'b1;
                        state     <= (produto == 54'd0) ? ROUND : NORM;
                    end
                end
                NORM: begin
                    if (sig[53]) begin
                        state <= ROUND;
                    end else begin
                        sig   <= {sig[52:0], 1'b0};
                        exp_w <= exp_w - 11'sd1;
                    end
                end
                ROUND: begin
                    if (zero_flag) begin
                        resultado <= {sgn, 31'b0};
                        overflow  <= 1'b0;
                        underflow <= 1'b0;
                    end else if (exp_rnd >= 11'sd255) begin
                        resultado <= {sgn, 8'hFF, 23'b0};
                        overflow  <= 1'b1;
                        underflow <= 1'b0;
                    end else if (exp_rnd <= 11'sd0) begin
                        resultado <= {sgn, 31'b0};
                        overflow  <= 1'b0;
                        underflow <= 1'b1;
                    end else begin
                        resultado <= {sgn, exp_rnd[7:0], frac_sum[22:0]};
                        overflow  <= 1'b0;
                        underflow <= 1'b0;
                    end
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    zero_flag <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
